// File: rtl/ara_pkg.sv
// Shared types and helpers for the L1 invalidation receiver.
// Provides the replay FSM state type and the line-offset width helper.
package ara_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } inval_state_e;

   // Number of byte-offset bits inside one L1 line.
   function automatic int unsigned line_offset(input int unsigned line_bytes);
      return $clog2(line_bytes);
   endfunction

endpackage

// File: rtl/inval_fifo.sv
// Small FIFO of pending line invalidations.
// Ports: push/data in, pop/head out, last-written entry, empty/full, flush.
module inval_fifo #(
   parameter int unsigned Width = 60,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic [Width-1:0] last_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  head_q;
   logic [PtrW-1:0]  tail_q;
   logic [PtrW:0]    count_q;

   assign head_o  = mem_q[head_q];
   assign last_o  = mem_q[tail_q - PtrW'(1)];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FullCnt);

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         mem_q[tail_q] <= data_i;
      end
   end

   // Flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            tail_q <= tail_q + PtrW'(1);
         end
         if (pop_i) begin
            head_q <= head_q + PtrW'(1);
         end
         if (push_i && !pop_i) begin
            count_q <= count_q + (PtrW+1)'(1);
         end else if (pop_i && !push_i) begin
            count_q <= count_q - (PtrW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/l1_inval_receiver.sv
// Buffers coherence line invalidations and replays them into the L1 tags.
// Ports: inval valid/ready/addr in, dc req/addr/gnt/done out, busy, count.
module l1_inval_receiver
   import ara_pkg::*;
#(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned FifoDepth   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 inval_valid_i,
   input  logic [AddrWidth-1:0] inval_addr_i,
   output logic                 inval_ready_o,
   output logic                 dc_req_o,
   output logic [AddrWidth-1:0] dc_addr_o,
   input  logic                 dc_gnt_i,
   input  logic                 dc_done_i,
   output logic                 busy_o,
   output logic [31:0]          inval_cnt_o
);

   localparam int unsigned OffW = line_offset(L1LineWidth);
   localparam int unsigned LaW  = AddrWidth - OffW;

   logic [LaW-1:0] la;
   logic [LaW-1:0] head;
   logic [LaW-1:0] last;
   logic [LaW-1:0] addr_q;
   logic           empty;
   logic           full;
   logic           hit;
   logic           push;
   logic           pop;
   logic [31:0]    cnt_q;
   logic           unused_off;

   inval_state_e state_q;
   inval_state_e state_d;

   assign la         = inval_addr_i[AddrWidth-1:OffW];
   assign unused_off = ^inval_addr_i[OffW-1:0];

   // Coalesce only against the newest buffered line, never the in-flight one.
   assign hit  = en_i && !empty && (la == last);
   assign inval_ready_o = ~en_i | ~full | hit;
   assign push = inval_valid_i && inval_ready_o && en_i && !hit;

   inval_fifo #(
      .Width (LaW),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (~en_i),
      .push_i  (push),
      .data_i  (la),
      .pop_i   (pop),
      .head_o  (head),
      .last_o  (last),
      .empty_o (empty),
      .full_o  (full)
   );

   // No pop while en_i is low: the entry is being flushed, not issued.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && en_i) begin
               pop     = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (dc_gnt_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dc_done_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            addr_q <= head;
         end
         if (state_q == REQ && dc_gnt_i) begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

   assign dc_req_o    = (state_q == REQ);
   assign dc_addr_o   = {addr_q, {OffW{1'b0}}};
   assign busy_o      = !empty || (state_q != IDLE);
   assign inval_cnt_o = cnt_q;

endmodule
